fb_burst_arbiter: RTL and testbench
===================================

Name: fb_burst_arbiter

Overview:
- Shares one burst-command port of the framebuffer DDR path between the input-side write engine and the output-side read engine.
- Each engine posts a burst request with an address. The arbiter picks a winner, drives the shared command, and tracks outstanding bursts per direction.
- Arbitration order: starvation override, then read-urgency priority, then round-robin.
- Sits in the axi_clock domain between the line-buffer engines and the AXI/MIG command adapter.

Parameters:
- BURST_LEN, 16, beats per burst; cmd_len = BURST_LEN-1.
- MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted bursts per direction (1..15).
- STARVE_LIMIT, 64, waiting cycles after which a requester is forced to win (1..255).
- ADDR_W, 29, byte address width.

Ports:
- axi_clock  in  1  sole clock.
- axi_resetn  in  1  asynchronous active-low reset.
- wr_req  in  1  write engine requests a burst; held until wr_gnt.
- wr_addr  in  ADDR_W  write burst address; stable while wr_req.
- wr_gnt  out  1  one-cycle pulse: write command accepted.
- wr_done  in  1  one-cycle pulse per completed write burst (B handshake).
- rd_req  in  1  read engine requests a burst; held until rd_gnt.
- rd_addr  in  ADDR_W  read burst address; stable while rd_req.
- rd_urgent  in  1  output line buffer near underrun.
- rd_gnt  out  1  one-cycle pulse: read command accepted.
- rd_done  in  1  one-cycle pulse per completed read burst (rlast beat).
- cmd_valid  out  1  shared command valid.
- cmd_ready  in  1  downstream accepts command.
- cmd_write  out  1  1=write, 0=read.
- cmd_addr  out  ADDR_W  registered command address.
- cmd_len  out  8  constant BURST_LEN-1.
- wr_outstanding  out  4  accepted uncompleted write bursts.
- rd_outstanding  out  4  accepted uncompleted read bursts.
- err  out  1  sticky: done received while the matching count was 0.
- stat_wr_bursts  out  32  granted write bursts (feature-gated).
- stat_rd_bursts  out  32  granted read bursts (feature-gated).

Behaviour:
- Reset (async assert, sync release) values:
  - cmd_valid=0, cmd_write=0, cmd_addr=0.
  - gnts=0, outstanding counts=0, err=0.
  - starve counters=0, rr pointer=read-next, stat counters=0.
- FSM states: IDLE, ISSUE.
- IDLE → ISSUE transition:
  - Eligible requester: req=1 and its outstanding count < MAX_OUTSTANDING.
  - If any requester is eligible, register winner, cmd_write and cmd_addr; next cycle cmd_valid=1.
  - Latency from req to cmd_valid is 1 cycle.
- Winner selection, first match wins:
  1. A starved requester (starve count == STARVE_LIMIT); if both are starved, rr pointer decides.
  2. Read, if rd_urgent and read is eligible.
  3. Round-robin: rr pointer's side if eligible, else the other side.
- ISSUE state:
  - cmd_valid, cmd_write and cmd_addr are held stable until cmd_ready.
  - On cmd_valid&cmd_ready: the matching gnt pulses that same cycle (combinational from cmd_ready), the count increments, the winner's starve count clears, rr points to the other side, and the FSM returns to IDLE.
  - Each command costs at least 2 cycles.
- Starve counters: increment each cycle the requester is eligible and not granted, saturating at STARVE_LIMIT; clear when its req is low.
- Outstanding counters:
  - Increment on grant, decrement on done; simultaneous grant and done leaves the count unchanged.
  - done at count 0 leaves the count at 0 and sets err.
  - A requester at MAX_OUTSTANDING is ineligible. If both are ineligible, the FSM stays in IDLE.
- Request withdrawal: req dropping while ISSUE is pending has no effect; the registered command completes and gnt still pulses. Requesters are required not to withdraw.
- Reset mid-ISSUE: cmd_valid drops immediately and no gnt is emitted.

Optional Feature:
- FB_ARB_STATS_EN defined: stat_wr_bursts/stat_rd_bursts increment on each respective grant, wrap at 2^32, reset to 0.
- Undefined: both outputs tied to 0 and no counter logic is generated.

Test Plan:
- Both req held, rd_urgent=0, cmd_ready=1, dones echoed 2 cycles after grant → grants alternate rd,wr,rd,wr; cmd_addr matches the granted side's address.
- rd_urgent=1 with both req held, write starve count below limit → read wins every arbitration until STARVE_LIMIT=64 cycles, then one write grant.
- wr_req only, no wr_done, MAX_OUTSTANDING=4 → exactly 4 wr_gnt pulses, then cmd_valid stays 0; one wr_done → a 5th grant follows within 2 cycles.
- cmd_ready held 0 for 10 cycles in ISSUE → cmd_valid, cmd_addr and cmd_write stable for all 10 cycles, no gnt; gnt pulses on the cycle cmd_ready rises.
- rd_done with rd_outstanding=0 → err=1 (sticky), count stays 0. Separately, grant and wr_done in the same cycle at count 2 → count stays 2.
- With FB_ARB_STATS_EN, 7 writes and 5 reads granted → stat_wr_bursts=7, stat_rd_bursts=5; axi_resetn pulse mid-ISSUE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fb_burst_arbiter.sv
// Shares one DDR burst-command port between the framebuffer write and read engines.
// Priority: starvation override, then read urgency, then round-robin. FB_ARB_STATS_EN adds burst counters.
module fb_burst_arbiter #(
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 64,
    parameter int ADDR_W          = 29
) (
    input  logic              axi_clock,
    input  logic              axi_resetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_gnt,
    input  logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    output logic              rd_gnt,
    input  logic              rd_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [3:0]        wr_outstanding,
    output logic [3:0]        rd_outstanding,
    output logic              err,
    output logic [31:0]       stat_wr_bursts,
    output logic [31:0]       stat_rd_bursts
);

    localparam logic [3:0] MAX_O   = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] STV_MAX = 8'(STARVE_LIMIT);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e            state_q;
    logic              cmd_valid_q, cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [3:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [7:0]        wr_stv_q, wr_stv_d, rd_stv_q, rd_stv_d;
    logic              rr_rd_q, rr_rd_d;
    logic              err_q, err_d;
    logic              wr_elig, rd_elig, wr_force, rd_force, pick_wr, accept;

    assign wr_elig  = wr_req && (wr_cnt_q < MAX_O);
    assign rd_elig  = rd_req && (rd_cnt_q < MAX_O);
    // A saturated starve count only overrides while the requester can actually be served.
    assign wr_force = wr_elig && (wr_stv_q == STV_MAX);
    assign rd_force = rd_elig && (rd_stv_q == STV_MAX);

    always_comb begin
        pick_wr = 1'b0;
        if (wr_force && rd_force) pick_wr = !rr_rd_q;
        else if (wr_force)        pick_wr = 1'b1;
        else if (rd_force)        pick_wr = 1'b0;
        else if (rd_urgent && rd_elig) pick_wr = 1'b0;
        else if (rr_rd_q)         pick_wr = !rd_elig;
        else                      pick_wr = wr_elig;
    end

    assign accept    = cmd_valid_q && cmd_ready;
    assign wr_gnt    = accept && cmd_write_q;
    assign rd_gnt    = accept && !cmd_write_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = 8'(BURST_LEN - 1);
    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;
    assign err = err_q;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (wr_elig || rd_elig) begin
                    state_q     <= ISSUE;
                    cmd_valid_q <= 1'b1;
                    cmd_write_q <= pick_wr;
                    cmd_addr_q  <= pick_wr ? wr_addr : rd_addr;
                end
                ISSUE: if (cmd_ready) begin
                    state_q     <= IDLE;
                    cmd_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_gnt && !wr_done) wr_cnt_d = wr_cnt_q + 4'd1;
        else if (!wr_gnt && wr_done && wr_cnt_q != 4'd0) wr_cnt_d = wr_cnt_q - 4'd1;

        rd_cnt_d = rd_cnt_q;
        if (rd_gnt && !rd_done) rd_cnt_d = rd_cnt_q + 4'd1;
        else if (!rd_gnt && rd_done && rd_cnt_q != 4'd0) rd_cnt_d = rd_cnt_q - 4'd1;

        err_d = err_q || (wr_done && wr_cnt_q == 4'd0) || (rd_done && rd_cnt_q == 4'd0);

        wr_stv_d = wr_stv_q;
        if (!wr_req || wr_gnt) wr_stv_d = 8'd0;
        else if (wr_elig && wr_stv_q != STV_MAX) wr_stv_d = wr_stv_q + 8'd1;

        rd_stv_d = rd_stv_q;
        if (!rd_req || rd_gnt) rd_stv_d = 8'd0;
        else if (rd_elig && rd_stv_q != STV_MAX) rd_stv_d = rd_stv_q + 8'd1;

        // After a write is accepted the read side is next, and vice versa.
        rr_rd_d = accept ? cmd_write_q : rr_rd_q;
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_stv_q <= '0;
            rd_stv_q <= '0;
            rr_rd_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_stv_q <= wr_stv_d;
            rd_stv_q <= rd_stv_d;
            rr_rd_q  <= rr_rd_d;
            err_q    <= err_d;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            if (wr_gnt) stat_wr_q <= stat_wr_q + 32'd1;
            if (rd_gnt) stat_rd_q <= stat_rd_q + 32'd1;
        end
    end

    assign stat_wr_bursts = stat_wr_q;
    assign stat_rd_bursts = stat_rd_q;
`else
    assign stat_wr_bursts = '0;
    assign stat_rd_bursts = '0;
`endif

endmodule

// File: tb/tb_fb_burst_arbiter.sv
// Scoreboard bench for fb_burst_arbiter: expected grants queued at stimulus time, popped on each gnt.
module tb_fb_burst_arbiter;

    localparam int AW       = 29;
    localparam int MAX_OUT  = 4;
    localparam int STARVE   = 64;
    // Each urgent read costs 2 cycles while the write waits STARVE cycles to saturate.
    localparam int N_URGENT_RD = STARVE / 2;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic axi_resetn;
    logic wr_req, wr_done, rd_req, rd_urgent, rd_done, cmd_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic wr_gnt, rd_gnt, cmd_valid, cmd_write, err;
    logic [AW-1:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [3:0] wr_outstanding, rd_outstanding;
    logic [31:0] stat_wr_bursts, stat_rd_bursts;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    logic s_wr_gnt, s_rd_gnt, s_valid, s_write;
    logic [AW-1:0] s_addr;
    logic echo;
    logic [1:0] wr_pend, rd_pend;

    fb_burst_arbiter #(.BURST_LEN(16), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE), .ADDR_W(AW)) dut (
        .axi_clock(clk), .axi_resetn(axi_resetn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent), .rd_gnt(rd_gnt), .rd_done(rd_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .err(err), .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] waddr(int k);
        return AW'(32'h0010_0000 + k * 32'h400);
    endfunction

    function automatic logic [AW-1:0] raddr(int k);
        return AW'(32'h0800_0000 + k * 32'h400);
    endfunction

    // Sample outputs mid-cycle, then drive at posedge+1; dones echo 2 cycles after a grant when enabled.
    task automatic tick();
        @(negedge clk);
        s_wr_gnt = wr_gnt; s_rd_gnt = rd_gnt; s_valid = cmd_valid; s_write = cmd_write; s_addr = cmd_addr;
        @(posedge clk); #1;
        wr_done = wr_pend[1];
        rd_done = rd_pend[1];
        wr_pend = {wr_pend[0], echo && s_wr_gnt};
        rd_pend = {rd_pend[0], echo && s_rd_gnt};
    endtask

    task automatic do_reset();
        axi_resetn = 1'b0;
        wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0; rd_urgent = 0; cmd_ready = 0;
        wr_addr = '0; rd_addr = '0; echo = 0; wr_pend = 0; rd_pend = 0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 axi_resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_valid, cmd_write, wr_gnt, rd_gnt, err} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {cmd_valid, cmd_write, wr_gnt, rd_gnt, err});
        end
        checks++;
        if (cmd_addr !== '0 || wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0) begin
            failures++; $display("FAIL reset_regs addr=%0h wo=%0d ro=%0d exp=0", cmd_addr, wr_outstanding, rd_outstanding);
        end
        checks++;
        if (cmd_len !== 8'd15 || stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0) begin
            failures++; $display("FAIL reset_len_stats len=%0d sw=%0d sr=%0d exp=15,0,0", cmd_len, stat_wr_bursts, stat_rd_bursts);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int wi = 0, ri = 0;
        do_reset();
        echo = 1; cmd_ready = 1;
        wr_addr = waddr(0); rd_addr = raddr(0);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{wr: 1'b0, addr: raddr(k)});
            sb.push_back('{wr: 1'b1, addr: waddr(k)});
        end
        wr_req = 1; rd_req = 1;
        checks++;
        if (s_valid !== 1'b0) begin
            failures++; $display("FAIL rr_pre_valid got=%b exp=0", s_valid);
        end
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            tick();
            if (s_wr_gnt || s_rd_gnt) begin
                e = sb.pop_front();
                checks++;
                if (s_wr_gnt !== e.wr || s_rd_gnt !== !e.wr || s_addr !== e.addr) begin
                    failures++;
                    $display("FAIL rr_grant got wr=%b rd=%b addr=%0h exp wr=%b addr=%0h", s_wr_gnt, s_rd_gnt, s_addr, e.wr, e.addr);
                end
                if (s_wr_gnt) begin wi++; wr_addr = waddr(wi); end
                if (s_rd_gnt) begin ri++; rd_addr = raddr(ri); end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL rr_timeout got=%0d pending exp=0", sb.size());
        end
        wr_req = 0; rd_req = 0;
        repeat (5) tick();
        checks++;
        if (wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0) begin
            failures++; $display("FAIL rr_drain wo=%0d ro=%0d exp=0", wr_outstanding, rd_outstanding);
        end
    endtask

    task automatic test_urgent_starve();
        exp_t e;
        do_reset();
        echo = 1; cmd_ready = 1; rd_urgent = 1;
        wr_addr = waddr(7); rd_addr = raddr(9);
        for (int k = 0; k < N_URGENT_RD; k++) sb.push_back('{wr: 1'b0, addr: raddr(9)});
        sb.push_back('{wr: 1'b1, addr: waddr(7)});
        wr_req = 1; rd_req = 1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            tick();
            if (s_wr_gnt || s_rd_gnt) begin
                e = sb.pop_front();
                checks++;
                if (s_wr_gnt !== e.wr || s_addr !== e.addr) begin
                    failures++;
                    $display("FAIL urgent_order left=%0d got wr=%b addr=%0h exp wr=%b addr=%0h", sb.size(), s_wr_gnt, s_addr, e.wr, e.addr);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL urgent_timeout got=%0d pending exp=0", sb.size());
        end
        wr_req = 0; rd_req = 0; rd_urgent = 0;
        repeat (5) tick();
    endtask

    task automatic test_max_outstanding();
        int n = 0;
        bit got = 0;
        do_reset();
        cmd_ready = 1; wr_addr = waddr(3); wr_req = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_wr_gnt) n++;
        end
        checks++;
        if (n != MAX_OUT || s_valid !== 1'b0) begin
            failures++; $display("FAIL maxout_grants got=%0d valid=%b exp=%0d valid=0", n, s_valid, MAX_OUT);
        end
        checks++;
        if (wr_outstanding !== 4'(MAX_OUT)) begin
            failures++; $display("FAIL maxout_count got=%0d exp=%0d", wr_outstanding, MAX_OUT);
        end
        wr_done = 1;
        for (int c = 0; c < 3 && !got; c++) begin
            tick();
            if (s_wr_gnt) got = 1;
        end
        wr_req = 0;
        checks++;
        if (!got) begin
            failures++; $display("FAIL maxout_refill got=0 exp=1");
        end
        tick();
        checks++;
        if (wr_outstanding !== 4'(MAX_OUT)) begin
            failures++; $display("FAIL maxout_after got=%0d exp=%0d", wr_outstanding, MAX_OUT);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rd_addr = raddr(5); rd_req = 1; cmd_ready = 0;
        tick();
        checks++;
        if (s_valid !== 1'b0) begin
            failures++; $display("FAIL bp_latency got=%b exp=0", s_valid);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_write !== 1'b0 || s_addr !== raddr(5) || s_rd_gnt || s_wr_gnt) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b wr=%b addr=%0h gnt=%b%b exp 1,0,%0h,00", c, s_valid, s_write, s_addr, s_wr_gnt, s_rd_gnt, raddr(5));
            end
        end
        cmd_ready = 1;
        tick();
        rd_req = 0; cmd_ready = 0;
        checks++;
        if (s_rd_gnt !== 1'b1 || s_wr_gnt !== 1'b0) begin
            failures++; $display("FAIL bp_gnt got rd=%b wr=%b exp rd=1 wr=0", s_rd_gnt, s_wr_gnt);
        end
        tick();
        checks++;
        if (s_valid !== 1'b0 || rd_outstanding !== 4'd1) begin
            failures++; $display("FAIL bp_after valid=%b ro=%0d exp 0,1", s_valid, rd_outstanding);
        end
    endtask

    task automatic test_err_and_simul();
        int n = 0;
        do_reset();
        rd_done = 1;
        tick();
        checks++;
        if (err !== 1'b1 || rd_outstanding !== 4'd0) begin
            failures++; $display("FAIL err_set err=%b ro=%0d exp 1,0", err, rd_outstanding);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got=%b exp=1", err);
        end

        do_reset();
        cmd_ready = 1; wr_addr = waddr(1); wr_req = 1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (s_wr_gnt) n++;
        end
        cmd_ready = 0;
        repeat (3) tick();
        checks++;
        if (wr_outstanding !== 4'd2 || s_valid !== 1'b1) begin
            failures++; $display("FAIL simul_pre wo=%0d valid=%b exp 2,1", wr_outstanding, s_valid);
        end
        cmd_ready = 1; wr_done = 1;
        tick();
        cmd_ready = 0; wr_req = 0;
        checks++;
        if (s_wr_gnt !== 1'b1 || wr_outstanding !== 4'd2 || err !== 1'b0) begin
            failures++; $display("FAIL simul_gnt_done gnt=%b wo=%0d err=%b exp 1,2,0", s_wr_gnt, wr_outstanding, err);
        end
    endtask

    task automatic test_stats_and_reset();
        int nw = 0, nr = 0;
        logic [31:0] exp_w, exp_r;
`ifdef FB_ARB_STATS_EN
        exp_w = 32'd7; exp_r = 32'd5;
`else
        exp_w = 32'd0; exp_r = 32'd0;
`endif
        do_reset();
        echo = 1; cmd_ready = 1; wr_addr = waddr(2); rd_addr = raddr(2);
        wr_req = 1;
        for (int c = 0; c < 80 && nw < 7; c++) begin
            tick();
            if (s_wr_gnt) nw++;
        end
        wr_req = 0; rd_req = 1;
        for (int c = 0; c < 80 && nr < 5; c++) begin
            tick();
            if (s_rd_gnt) nr++;
        end
        rd_req = 0;
        repeat (4) tick();
        checks++;
        if (nw != 7 || nr != 5) begin
            failures++; $display("FAIL stats_grants got w=%0d r=%0d exp 7,5", nw, nr);
        end
        checks++;
        if (stat_wr_bursts !== exp_w || stat_rd_bursts !== exp_r) begin
            failures++; $display("FAIL stats_count got w=%0d r=%0d exp %0d,%0d", stat_wr_bursts, stat_rd_bursts, exp_w, exp_r);
        end

        echo = 0; cmd_ready = 0; wr_req = 1; rd_req = 1; rd_done = 1;
        tick();
        rd_done = 0;
        tick();
        checks++;
        if (s_valid !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL midreset_pre valid=%b err=%b exp 1,1", s_valid, err);
        end
        cmd_ready = 1;
        #2 axi_resetn = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_write, wr_gnt, rd_gnt, err} !== 5'b0 || cmd_addr !== '0) begin
            failures++; $display("FAIL midreset_ctrl got=%b addr=%0h exp=00000 addr=0", {cmd_valid, cmd_write, wr_gnt, rd_gnt, err}, cmd_addr);
        end
        checks++;
        if (wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0 || stat_wr_bursts !== 32'd0 || stat_rd_bursts !== 32'd0) begin
            failures++; $display("FAIL midreset_cnt wo=%0d ro=%0d sw=%0d sr=%0d exp 0", wr_outstanding, rd_outstanding, stat_wr_bursts, stat_rd_bursts);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_urgent_starve();
        test_max_outstanding();
        test_backpressure();
        test_err_and_simul();
        test_stats_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
